riscv_decode_stage: RTL and testbench

- IF/ID pipeline stage that registers fetched instructions and splits them into fields.
- Packs the raw immediate bits into the low-aligned form the downstream sign-extend stage expects: 12-bit fields in [11:0], 20-bit fields in [19:0].
- Two-entry skid buffer with valid/ready handshakes on both sides. Supports flush for branch/jump redirects.

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/riscv_imm_pack.sv | 36 +++
 rtl/riscv_decode_stage.sv | 88 ++++++++
 tb/tb_riscv_decode_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcode encodings, field positions
// and the IF/ID bundle.
package riscv_pkg;

    localparam int ILEN = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;

    typedef struct packed {
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } if_id_t;

endpackage

// File: rtl/riscv_imm_pack.sv
// Packs raw immediate bits low-aligned for the sign-extend stage
// and flags unsupported opcodes.
module riscv_imm_pack
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm_raw,
    output logic        illegal
);

    always_comb begin
        imm_raw = '0;
        illegal = 1'b0;
        unique case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR:
                imm_raw = {20'b0, instr[31:20]};
            OP_STORE:
                imm_raw = {20'b0, instr[31:25], instr[11:7]};
            // imm[12:1]; consumer restores the implicit zero LSB
            OP_BRANCH:
                imm_raw = {20'b0, instr[31], instr[7],
                           instr[30:25], instr[11:8]};
            // imm[20:1]
            OP_JAL:
                imm_raw = {12'b0, instr[31], instr[19:12],
                           instr[20], instr[30:21]};
            OP_AUIPC, OP_LUI:
                imm_raw = {12'b0, instr[31:12]};
            OP_REG:
                imm_raw = '0;
            default:
                illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/riscv_decode_stage.sv
// IF/ID stage: output register plus one skid entry, valid/ready on
// both sides, flush for redirects, field split of the held instruction.
module riscv_decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [31:0]     imm_raw,
    output logic            illegal
);

    if_id_t out_q;
    if_id_t skid_q;
    if_id_t in_d;
    logic   out_valid_q;
    logic   skid_valid_q;
    logic   accept;
    logic   out_free;
    logic   xfer;
    logic   illegal_raw;

    assign in_d     = '{pc: in_pc, instr: in_instr};
    assign accept   = in_valid && !skid_valid_q && !flush;
    assign xfer     = out_valid_q && out_ready;
    assign out_free = !out_valid_q || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (skid_valid_q && out_free) begin
            out_q        <= skid_q;
            out_valid_q  <= 1'b1;
            skid_valid_q <= 1'b0;
        end else if (accept && out_free) begin
            out_q        <= in_d;
            out_valid_q  <= 1'b1;
        end else if (accept) begin
            skid_q       <= in_d;
            skid_valid_q <= 1'b1;
        end else if (xfer) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign in_ready  = !skid_valid_q;
    assign out_valid = out_valid_q;
    assign out_pc    = out_q.pc;
    assign out_instr = out_q.instr;
    assign opcode    = out_q.instr[OPC_LSB +: 7];
    assign rd        = out_q.instr[RD_LSB  +: 5];
    assign rs1       = out_q.instr[RS1_LSB +: 5];
    assign rs2       = out_q.instr[RS2_LSB +: 5];
    assign funct3    = out_q.instr[F3_LSB  +: 3];
    assign funct7    = out_q.instr[F7_LSB  +: 7];

    riscv_imm_pack u_imm_pack (
        .instr   (out_q.instr),
        .imm_raw (imm_raw),
        .illegal (illegal_raw)
    );

    // An empty register holds zero, which would otherwise read as illegal
    assign illegal = out_valid_q && illegal_raw;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Scoreboard bench for riscv_decode_stage: expected words queued at
// drive time, popped and compared on each output transfer.
module tb_riscv_decode_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_raw;
    logic        illegal;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;

    riscv_decode_stage #(.XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm_raw   (imm_raw),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] pc,
                        input logic [31:0] instr,
                        input logic [31:0] imm,
                        input logic        ill);
        bit ok;
        exp_t e;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        e = '{pc: pc, instr: instr, imm: imm, ill: ill};
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 100; n++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        #2;
        check("drain_left", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", out_instr, 32'hDEAD_BEEF);
            end else begin
                e = sb.pop_front();
                check("pc",     out_pc,            e.pc);
                check("instr",  out_instr,         e.instr);
                check("opcode", 32'(opcode),       32'(e.instr[6:0]));
                check("rd",     32'(rd),           32'(e.instr[11:7]));
                check("rs1",    32'(rs1),          32'(e.instr[19:15]));
                check("rs2",    32'(rs2),          32'(e.instr[24:20]));
                check("funct3", 32'(funct3),       32'(e.instr[14:12]));
                check("funct7", 32'(funct7),       32'(e.instr[31:25]));
                check("imm",    imm_raw,           e.imm);
                check("illegal", 32'(illegal),     32'(e.ill));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_pc",    out_pc,         32'd0);
        check("rst_imm",       imm_raw,        32'd0);
        check("rst_illegal",   32'(illegal),   32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        send(32'h100, 32'hFFF0_0093, 32'h0000_0FFF, 1'b0);
        check("lat_addi", 32'(out_valid), 32'd1);
        send(32'h104, 32'h0011_2623, 32'h0000_000C, 1'b0);
        send(32'h108, 32'hFE00_0EE3, 32'h0000_0FFE, 1'b0);
        send(32'h10C, 32'h0080_00EF, 32'h0000_0004, 1'b0);
        send(32'h110, 32'h1234_52B7, 32'h0001_2345, 1'b0);
        send(32'h114, 32'h0000_007F, 32'h0000_0000, 1'b1);
        check("lat_illegal", 32'(out_valid), 32'd1);
        drain();

        @(posedge clk);
        #1;
        out_ready = 1'b0;
        fork
            begin
                send(32'h200, 32'h0050_0113, 32'h0000_0005, 1'b0);
                send(32'h204, 32'h00A0_0193, 32'h0000_000A, 1'b0);
                send(32'h208, 32'h0031_00B3, 32'h0000_0000, 1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                check("bp_in_ready_b", 32'(in_ready), 32'd0);
                check("bp_out_valid",  32'(out_valid), 32'd1);
                @(posedge clk);
                #1;
                check("bp_c_held", 32'(in_ready), 32'd0);
                out_ready = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_no_gap", 32'(out_valid), 32'd1);
                end
            end
        join
        drain();

        out_ready = 1'b0;
        send(32'h300, 32'h0010_0093, 32'h0000_0001, 1'b0);
        send(32'h304, 32'h0020_0093, 32'h0000_0002, 1'b0);
        in_valid = 1'b1;
        in_pc    = 32'h308;
        in_instr = 32'h0030_0093;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_in_ready",  32'(in_ready),  32'd1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send(32'h400, 32'h0000_1517, 32'h0000_0001, 1'b0);
        drain();

        out_ready = 1'b0;
        send(32'h500, 32'h0040_0093, 32'h0000_0004, 1'b0);
        send(32'h504, 32'h0050_0093, 32'h0000_0005, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_in_ready",  32'(in_ready),  32'd1);
        sb.delete();
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(32'h600, 32'h00C0_0093, 32'h0000_000C, 1'b0);
        check("ar_lat", 32'(out_valid), 32'd1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
